// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer driving every datapath control strobe (fetch T0-T2, execute T3-T7).
// Latency: outputs depend on the registered state (plus IR during execute); 4/6/7/8 cycles per instruction.
// Backpressure: none; Stop diverts the next entry into T0 to HALT, Clear aborts to RST on the next edge.
// Ports: Clock, Clear (synchronous, active-high); IR (opcode IR[31:27]); CON_FF branch condition;
//        Stop halt request; Run status; ALU_op (non-zero only with ZLowIn); one 1-bit strobe per datapath port.
module control_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic [4:0]  ALU_op,
  output logic        IncPC,
  output logic        PC_enable,
  output logic        PCout,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        MDR_read,
  output logic        MDRout,
  output logic        RAM_write,
  output logic        IR_enable,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic        BAout,
  output logic        Cout,
  output logic        Y_enable,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        HIout,
  output logic        LOout,
  output logic        CON_enable,
  output logic        OutPort_enable,
  output logic        InPortout
);

  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_OUT  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11010;

  state_t     state, next_state, last_state;
  logic [4:0] opcode;
  logic       is_rtype;
  logic       is_mem;        // ld/ldi/st share the base+offset address computation
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign is_rtype  = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) || (opcode == OP_OR);
  assign is_mem    = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
  assign Run       = (state != RST) && (state != HALT);

  // Final execute state for the current opcode; unlisted opcodes (nop, halt, unknown) end in T3.
  always_comb begin
    last_state = T3;
    if (is_rtype || opcode == OP_LDI)          last_state = T5;
    else if (opcode == OP_MUL || opcode == OP_BR) last_state = T6;
    else if (opcode == OP_LD || opcode == OP_ST)  last_state = T7;
  end

  always_ff @(posedge Clock) begin
    if (Clear) state <= RST;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RST: next_state = T0;
      T0:  next_state = T1;
      T1:  next_state = T2;
      T2:  next_state = T3;
      T3, T4, T5, T6, T7: begin
        if (state == T3 && opcode == OP_HALT) next_state = HALT;
        else if (state == last_state)         next_state = T0;
        else                                  next_state = state_t'(state + 4'd1);
      end
      HALT:    next_state = HALT;
      default: next_state = RST;
    endcase
    // Stop is only honoured at an instruction boundary.
    if (next_state == T0 && Stop) next_state = HALT;
  end

  always_comb begin
    ALU_op = 5'd0;
    IncPC = 1'b0; PC_enable = 1'b0; PCout = 1'b0;
    MAR_enable = 1'b0; MDR_enable = 1'b0; MDR_read = 1'b0; MDRout = 1'b0;
    RAM_write = 1'b0; IR_enable = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; R_in = 1'b0; R_out = 1'b0;
    BAout = 1'b0; Cout = 1'b0; Y_enable = 1'b0;
    ZLowIn = 1'b0; ZHighIn = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0;
    HI_enable = 1'b0; LO_enable = 1'b0; HIout = 1'b0; LOout = 1'b0;
    CON_enable = 1'b0; OutPort_enable = 1'b0; InPortout = 1'b0;
    case (state)
      T0: begin PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; ALU_op = OP_ADD; end
      T1: begin ZLowout = 1'b1; PC_enable = 1'b1; MDR_read = 1'b1; MDR_enable = 1'b1; end
      T2: begin MDRout = 1'b1; IR_enable = 1'b1; end
      T3: begin
        if (is_rtype)              begin Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
        else if (opcode == OP_MUL) begin Gra = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
        else if (is_mem)           begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
        else if (opcode == OP_BR)  begin Gra = 1'b1; R_out = 1'b1; CON_enable = 1'b1; end
        else if (opcode == OP_JR)  begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
        else if (opcode == OP_MFHI) begin Gra = 1'b1; R_in = 1'b1; HIout = 1'b1; end
        else if (opcode == OP_MFLO) begin Gra = 1'b1; R_in = 1'b1; LOout = 1'b1; end
        else if (opcode == OP_IN)  begin InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        else if (opcode == OP_OUT) begin Gra = 1'b1; R_out = 1'b1; OutPort_enable = 1'b1; end
      end
      T4: begin
        if (is_rtype)              begin Grc = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; ALU_op = opcode; end
        else if (opcode == OP_MUL) begin
          Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; ALU_op = OP_MUL;
        end
        else if (is_mem)           begin Cout = 1'b1; ZLowIn = 1'b1; ALU_op = OP_ADD; end
        else if (opcode == OP_BR)  begin PCout = 1'b1; Y_enable = 1'b1; end
      end
      T5: begin
        if (is_rtype || opcode == OP_LDI) begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        else if (opcode == OP_MUL) begin ZLowout = 1'b1; LO_enable = 1'b1; end
        else if (is_mem)           begin ZLowout = 1'b1; MAR_enable = 1'b1; end
        else if (opcode == OP_BR)  begin Cout = 1'b1; ZLowIn = 1'b1; ALU_op = OP_ADD; end
      end
      T6: begin
        if (opcode == OP_MUL)      begin ZHighout = 1'b1; HI_enable = 1'b1; end
        else if (opcode == OP_LD)  begin MDR_read = 1'b1; MDR_enable = 1'b1; end
        else if (opcode == OP_ST)  begin Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1; end
        else if (opcode == OP_BR)  begin ZLowout = 1'b1; PC_enable = CON_FF; end
      end
      T7: begin
        if (opcode == OP_LD)       begin MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        else if (opcode == OP_ST)  begin MDRout = 1'b1; RAM_write = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: checks control_unit strobe sequences against per-instruction microprogram tables.
// Latency: one comparison per clock, sampled on the falling edge.
// Backpressure: n/a; inputs are driven right after each falling-edge sample.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Clear, CON_FF, Stop;
  logic [31:0] IR;
  logic        Run;
  logic [4:0]  ALU_op;
  logic IncPC, PC_enable, PCout, MAR_enable, MDR_enable, MDR_read, MDRout, RAM_write, IR_enable;
  logic Gra, Grb, Grc, R_in, R_out, BAout, Cout, Y_enable;
  logic ZLowIn, ZHighIn, ZLowout, ZHighout, HI_enable, LO_enable, HIout, LOout;
  logic CON_enable, OutPort_enable, InPortout;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .Run(Run), .ALU_op(ALU_op),
    .IncPC(IncPC), .PC_enable(PC_enable), .PCout(PCout),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .MDR_read(MDR_read), .MDRout(MDRout),
    .RAM_write(RAM_write), .IR_enable(IR_enable),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out), .BAout(BAout), .Cout(Cout),
    .Y_enable(Y_enable), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .ZLowout(ZLowout), .ZHighout(ZHighout),
    .HI_enable(HI_enable), .LO_enable(LO_enable), .HIout(HIout), .LOout(LOout),
    .CON_enable(CON_enable), .OutPort_enable(OutPort_enable), .InPortout(InPortout)
  );

  // Strobe bit positions inside the observed/expected word.
  localparam logic [27:0] M_INCPC  = 28'd1 << 0,  M_PCEN   = 28'd1 << 1,  M_PCOUT  = 28'd1 << 2;
  localparam logic [27:0] M_MAR    = 28'd1 << 3,  M_MDREN  = 28'd1 << 4,  M_MDRRD  = 28'd1 << 5;
  localparam logic [27:0] M_MDROUT = 28'd1 << 6,  M_RAMWR  = 28'd1 << 7,  M_IREN   = 28'd1 << 8;
  localparam logic [27:0] M_GRA    = 28'd1 << 9,  M_GRB    = 28'd1 << 10, M_GRC    = 28'd1 << 11;
  localparam logic [27:0] M_RIN    = 28'd1 << 12, M_ROUT   = 28'd1 << 13, M_BAOUT  = 28'd1 << 14;
  localparam logic [27:0] M_COUT   = 28'd1 << 15, M_YEN    = 28'd1 << 16, M_ZLI    = 28'd1 << 17;
  localparam logic [27:0] M_ZHI    = 28'd1 << 18, M_ZLO    = 28'd1 << 19, M_ZHO    = 28'd1 << 20;
  localparam logic [27:0] M_HIEN   = 28'd1 << 21, M_LOEN   = 28'd1 << 22, M_HIOUT  = 28'd1 << 23;
  localparam logic [27:0] M_LOOUT  = 28'd1 << 24, M_CONEN  = 28'd1 << 25, M_OPEN   = 28'd1 << 26;
  localparam logic [27:0] M_INPOUT = 28'd1 << 27;

  logic [33:0] act_w;
  assign act_w = {Run, ALU_op, InPortout, OutPort_enable, CON_enable, LOout, HIout, LO_enable,
                  HI_enable, ZHighout, ZLowout, ZHighIn, ZLowIn, Y_enable, Cout, BAout, R_out,
                  R_in, Grc, Grb, Gra, IR_enable, RAM_write, MDRout, MDR_read, MDR_enable,
                  MAR_enable, PCout, PC_enable, IncPC};

  logic [33:0] exp_q[$];

  task automatic chk(input string tag, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [33:0] mk(input logic [27:0] s, input logic [4:0] alu);
    return {1'b1, alu, s};
  endfunction

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Expected per-cycle words for one instruction, fetch included.
  task automatic build_seq(input logic [4:0] op, input logic con);
    exp_q.delete();
    exp_q.push_back(mk(M_PCOUT | M_MAR | M_INCPC | M_ZLI, 5'd3));
    exp_q.push_back(mk(M_ZLO | M_PCEN | M_MDRRD | M_MDREN, 5'd0));
    exp_q.push_back(mk(M_MDROUT | M_IREN, 5'd0));
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        exp_q.push_back(mk(M_GRB | M_ROUT | M_YEN, 5'd0));
        exp_q.push_back(mk(M_GRC | M_ROUT | M_ZLI, op));
        exp_q.push_back(mk(M_ZLO | M_GRA | M_RIN, 5'd0));
      end
      5'd15: begin
        exp_q.push_back(mk(M_GRA | M_ROUT | M_YEN, 5'd0));
        exp_q.push_back(mk(M_GRB | M_ROUT | M_ZLI | M_ZHI, 5'd15));
        exp_q.push_back(mk(M_ZLO | M_LOEN, 5'd0));
        exp_q.push_back(mk(M_ZHO | M_HIEN, 5'd0));
      end
      5'd0, 5'd1, 5'd2: begin
        exp_q.push_back(mk(M_GRB | M_BAOUT | M_YEN, 5'd0));
        exp_q.push_back(mk(M_COUT | M_ZLI, 5'd3));
        if (op == 5'd1) exp_q.push_back(mk(M_ZLO | M_GRA | M_RIN, 5'd0));
        else            exp_q.push_back(mk(M_ZLO | M_MAR, 5'd0));
        if (op == 5'd0) begin
          exp_q.push_back(mk(M_MDRRD | M_MDREN, 5'd0));
          exp_q.push_back(mk(M_MDROUT | M_GRA | M_RIN, 5'd0));
        end else if (op == 5'd2) begin
          exp_q.push_back(mk(M_GRA | M_ROUT | M_MDREN, 5'd0));
          exp_q.push_back(mk(M_MDROUT | M_RAMWR, 5'd0));
        end
      end
      5'd18: begin
        exp_q.push_back(mk(M_GRA | M_ROUT | M_CONEN, 5'd0));
        exp_q.push_back(mk(M_PCOUT | M_YEN, 5'd0));
        exp_q.push_back(mk(M_COUT | M_ZLI, 5'd3));
        exp_q.push_back(mk(M_ZLO | (con ? M_PCEN : 28'd0), 5'd0));
      end
      5'd19: exp_q.push_back(mk(M_GRA | M_ROUT | M_PCEN, 5'd0));
      5'd23: exp_q.push_back(mk(M_GRA | M_RIN | M_HIOUT, 5'd0));
      5'd24: exp_q.push_back(mk(M_GRA | M_RIN | M_LOOUT, 5'd0));
      5'd22: exp_q.push_back(mk(M_INPOUT | M_GRA | M_RIN, 5'd0));
      5'd21: exp_q.push_back(mk(M_GRA | M_ROUT | M_OPEN, 5'd0));
      default: exp_q.push_back(mk(28'd0, 5'd0));
    endcase
  endtask

  // Halted: nothing but zeros whatever the inputs do; then Clear (with a random Stop) back to RST.
  task automatic hold_and_recover(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("halt_c%0d", i), act_w, 34'd0);
      Stop = 1'($urandom); IR = $urandom; CON_FF = 1'($urandom);
    end
    Clear = 1'b1; Stop = 1'($urandom);
    tick();
    chk("halt_clear", act_w, 34'd0);
    Clear = 1'b0; Stop = 1'b0;
  endtask

  // Runs one instruction from T0. abort_k aborts with Clear after that cycle's check.
  task automatic run_instr(input logic [31:0] ir, input logic con, input logic stop_end,
                           input int abort_k, input int hold_n);
    logic [4:0] op;
    int len;
    op = ir[31:27];
    build_seq(op, con);
    len = exp_q.size();
    for (int k = 0; k < len; k++) begin
      tick();
      chk($sformatf("op%0d_c%0d", op, k), act_w, exp_q[k]);
      if (k == abort_k) begin
        Clear = 1'b1; Stop = 1'b1;   // Clear must win over Stop
        tick();
        chk($sformatf("abort_op%0d_c%0d", op, k), act_w, 34'd0);
        Clear = 1'b0; Stop = 1'b0;
        return;
      end
      if (k < 2)       IR = $urandom;
      else if (k == 2) IR = ir;
      CON_FF = (k + 1 == 6) ? con : 1'($urandom);
      Stop   = (k == len - 1) ? stop_end : 1'($urandom);
    end
    if (stop_end || op == 5'd26) hold_and_recover(hold_n);
  endtask

  logic [4:0] dir_ops[12] = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd15, 5'd19, 5'd21, 5'd22, 5'd24,
                              5'd25, 5'd8};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    Clear = 1'b1; Stop = 1'b0; IR = 32'd0; CON_FF = 1'b0;
    tick();
    chk("reset_c0", act_w, 34'd0);
    Stop = 1'b1;
    tick();
    chk("reset_c1", act_w, 34'd0);
    Stop = 1'b0; Clear = 1'b0;

    run_instr(32'hB9000000, 1'b0, 1'b0, -1, 0);   // mfhi
    run_instr(32'h18918000, 1'b0, 1'b0, -1, 0);   // add r1,r2,r3
    run_instr(32'h90000014, 1'b0, 1'b0, -1, 0);   // br, not taken
    run_instr(32'h90000014, 1'b1, 1'b0, -1, 0);   // br, taken
    foreach (dir_ops[i]) run_instr({dir_ops[i], 27'($urandom)}, 1'($urandom), 1'b0, -1, 0);
    run_instr(32'h10000000, 1'b0, 1'b0, -1, 0);   // st
    run_instr(32'hD0000000, 1'b0, 1'b0, -1, 10);  // halt
    run_instr(32'h00000000, 1'b0, 1'b0, 5, 0);    // ld aborted in T5
    run_instr(32'h18918000, 1'b0, 1'b1, -1, 4);   // add with Stop at the end

    for (int n = 0; n < 60; n++) begin
      run_instr($urandom, 1'($urandom), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
